// File: rtl/knn_seq_ctrl_pkg.sv
// Shared types and helpers for the KNN sequencer slice.
// Build option: KNN_SEQ_PERF_EN adds the perf_cycles busy-cycle counter to knn_seq_ctrl.
package knn_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStream,
    StDrain,
    StRead,
    StEmpty
  } knn_state_e;

  // Counter width that stays legal for tiny counts.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/knn_train_fetch.sv
// Training-RAM address generator: walks 0..n_train-1 once per go pulse and produces a
// read-valid strobe aligned with the RAM's one-cycle read latency.
module knn_train_fetch #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [CNT_W-1:0] n_train,
  output logic [CNT_W-1:0] tr_addr,
  output logic             rd_valid,
  output logic             last_valid
);

  logic [CNT_W-1:0] addr_q;
  logic             active_q;
  logic             valid_q;

  // go is only issued for n_train != 0, so n_train - 1 never underflows here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (go) begin
      addr_q   <= '0;
      active_q <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= active_q;
      if (active_q) begin
        if (addr_q == n_train - 1'b1) begin
          active_q <= 1'b0;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign tr_addr    = addr_q;
  assign rd_valid   = valid_q;
  // Strobe for the final sample: data still arriving but no further address issued.
  assign last_valid = valid_q & ~active_q;

endmodule

// File: rtl/knn_seq_ctrl.sv
// Sequencer for one pipeline_sorter KNN solver: clear, stream training set, drain, read out.
// Build option: KNN_SEQ_PERF_EN adds output perf_cycles (busy cycles of the last run).
module knn_seq_ctrl
  import knn_seq_ctrl_pkg::*;
#(
  parameter int unsigned HW_K     = 10,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned LABEL_W  = 8,
  parameter int unsigned SORT_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_train,
  input  logic [2*COORD_W-1:0]    test_xy,
  output logic [CNT_W-1:0]        tr_addr,
  input  logic [2*COORD_W-1:0]    tr_rdata,
  output logic                    srt_clr,
  output logic                    srt_valid,
  output logic [COORD_W-1:0]      srt_x1,
  output logic [COORD_W-1:0]      srt_y1,
  output logic [COORD_W-1:0]      srt_x2,
  output logic [COORD_W-1:0]      srt_y2,
  output logic                    srt_done,
  output logic [$clog2(HW_K)-1:0] srt_sel,
  input  logic [LABEL_W-1:0]      srt_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(HW_K)-1:0] res_rank,
  output logic [LABEL_W-1:0]      res_label,
  output logic                    busy,
  output logic                    run_done
`ifdef KNN_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam int unsigned SelW = $clog2(HW_K);
  localparam int unsigned LatW = cnt_width(SORT_LAT);
  localparam logic [SelW-1:0] LastRank = SelW'(HW_K - 1);
  localparam logic [LatW-1:0] LastLat  = LatW'(SORT_LAT - 1);

  knn_state_e           state_q;
  logic [CNT_W-1:0]     n_train_q;
  logic [2*COORD_W-1:0] test_q;
  logic [LatW-1:0]      lat_q;
  logic [SelW-1:0]      sel_q;
  logic                 clr_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 srt_done_q;
  logic                 res_valid_q;

  logic go;
  logic last_valid;
  logic start_acc;

  assign start_acc = (state_q == StIdle) && !busy_q && start;
  assign go        = (state_q == StFetch) && (n_train_q != '0);

  knn_train_fetch #(
    .CNT_W (CNT_W)
  ) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .n_train    (n_train_q),
    .tr_addr    (tr_addr),
    .rd_valid   (srt_valid),
    .last_valid (last_valid)
  );

  // busy_q stays high through the run_done cycle, which is spent in StIdle or StEmpty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      n_train_q   <= '0;
      test_q      <= '0;
      lat_q       <= '0;
      sel_q       <= '0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      srt_done_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start_acc) begin
            n_train_q <= n_train;
            test_q    <= test_xy;
            clr_q     <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StFetch;
          end
        end
        StFetch: begin
          if (n_train_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StEmpty;
          end else begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (last_valid) begin
            lat_q <= '0;
            if (SORT_LAT == 0) begin
              sel_q       <= '0;
              srt_done_q  <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= StRead;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (lat_q == LastLat) begin
            sel_q       <= '0;
            srt_done_q  <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= StRead;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StRead: begin
          if (res_ready) begin
            if (sel_q == LastRank) begin
              sel_q       <= '0;
              srt_done_q  <= 1'b0;
              res_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StIdle;
            end else begin
              sel_q <= sel_q + 1'b1;
            end
          end
        end
        StEmpty: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign srt_clr   = clr_q;
  assign busy      = busy_q;
  assign run_done  = done_q;
  assign srt_done  = srt_done_q;
  assign srt_sel   = sel_q;
  assign res_valid = res_valid_q;
  assign res_rank  = sel_q;
  assign res_label = res_valid_q ? srt_data : '0;
  assign srt_x1    = test_q[COORD_W-1:0];
  assign srt_y1    = test_q[2*COORD_W-1:COORD_W];
  // Training coordinates are forced to zero outside sample strobes.
  assign srt_x2    = srt_valid ? tr_rdata[COORD_W-1:0] : '0;
  assign srt_y2    = srt_valid ? tr_rdata[2*COORD_W-1:COORD_W] : '0;

`ifdef KNN_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != '1)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// Self-checking bench for knn_seq_ctrl with a behavioural training RAM and K-nearest sorter.
module tb_knn_seq_ctrl;

  localparam int K   = 4;
  localparam int LAT = 2;

  typedef struct {
    logic [15:0] n;
    logic [31:0] xy;
    logic [7:0]  lab [K];
  } vec_t;

  typedef struct {
    logic [1:0] rank;
    logic [7:0] label;
  } exp_t;

  typedef struct {
    int unsigned d [K];
    logic [7:0]  l [K];
  } slots_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] n_train = '0;
  logic [31:0] test_xy = '0;
  logic [15:0] tr_addr;
  logic [31:0] tr_rdata;
  logic        srt_clr, srt_valid, srt_done;
  logic [15:0] srt_x1, srt_y1, srt_x2, srt_y2;
  logic [1:0]  srt_sel;
  logic [7:0]  srt_data;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [1:0]  res_rank;
  logic [7:0]  res_label;
  logic        busy, run_done;
`ifdef KNN_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int scyc, dcyc, vfirst, vlast;
  int vcnt = 0;
  int dcnt = 0;
  exp_t q[$];
  exp_t e;
  vec_t vecs [5];
  logic [31:0] ram [8];
  slots_t slots;
  logic [7:0] samp;

  knn_seq_ctrl #(
    .HW_K     (K),
    .CNT_W    (16),
    .COORD_W  (16),
    .LABEL_W  (8),
    .SORT_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n_train     (n_train),
    .test_xy     (test_xy),
    .tr_addr     (tr_addr),
    .tr_rdata    (tr_rdata),
    .srt_clr     (srt_clr),
    .srt_valid   (srt_valid),
    .srt_x1      (srt_x1),
    .srt_y1      (srt_y1),
    .srt_x2      (srt_x2),
    .srt_y2      (srt_y2),
    .srt_done    (srt_done),
    .srt_sel     (srt_sel),
    .srt_data    (srt_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_rank    (res_rank),
    .res_label   (res_label),
    .busy        (busy),
    .run_done    (run_done)
`ifdef KNN_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tr_rdata <= ram[tr_addr[2:0]];

  function automatic int unsigned absd(logic [15:0] a, logic [15:0] b);
    return (a > b) ? int'(a - b) : int'(b - a);
  endfunction

  function automatic slots_t empty_slots();
    slots_t s;
    for (int i = 0; i < K; i++) begin
      s.d[i] = 32'hFFFF_FFFF;
      s.l[i] = 8'hFF;
    end
    return s;
  endfunction

  function automatic slots_t ins(slots_t s, int unsigned d, logic [7:0] l);
    slots_t r = s;
    int p = K;
    for (int i = K - 1; i >= 0; i--) if (d < s.d[i]) p = i;
    for (int i = K - 1; i > p; i--) begin
      r.d[i] = s.d[i-1];
      r.l[i] = s.l[i-1];
    end
    if (p < K) begin
      r.d[p] = d;
      r.l[p] = l;
    end
    return r;
  endfunction

  // Sorter model: label of each sample is 0x10 + arrival index.
  always @(posedge clk) begin
    if (rst || srt_clr) begin
      slots <= empty_slots();
      samp  <= 8'h00;
    end else if (srt_valid) begin
      slots <= ins(slots, absd(srt_x1, srt_x2) + absd(srt_y1, srt_y2), 8'h10 + samp);
      samp  <= samp + 8'h01;
    end
  end
  assign srt_data = slots.l[srt_sel];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (srt_valid) begin
      if (vcnt == 0) vfirst = cyc;
      vlast = cyc;
      vcnt++;
    end
    if (run_done) begin
      dcnt++;
      dcyc = cyc;
    end
    if (res_valid && res_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("res_rank", 64'(res_rank), 64'(e.rank));
        check("res_label", 64'(res_label), 64'(e.label));
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, 64'({tr_addr, srt_clr, srt_valid, srt_done, srt_sel, res_valid,
                              res_rank, res_label, busy, run_done}), 64'd0);
    check({tag, "_coord"}, {srt_x1, srt_y1, srt_x2, srt_y2}, 64'd0);
  endtask

  task automatic start_run(input vec_t v);
    if (v.n != 0) begin
      for (int r = 0; r < K; r++) q.push_back('{rank: 2'(r), label: v.lab[r]});
    end
    vcnt = 0;
    dcnt = 0;
    @(posedge clk);
    #1;
    n_train = v.n;
    test_xy = v.xy;
    start   = 1'b1;
    scyc    = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_run(input vec_t v, input int extra);
    int n = 0;
    int lat;
    lat = (v.n == 0) ? 2 : int'(v.n) + 3 + LAT + K + extra;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("busy_timeout", 64'd1, 64'd0);
    check("valid_cnt", 64'(vcnt), 64'(v.n));
    check("valid_contig", (vcnt == 0) ? 64'd0 : 64'(vlast - vfirst + 1), 64'(v.n));
    check("done_cnt", 64'(dcnt), 64'd1);
    check("done_lat", 64'(dcyc - scyc), 64'(lat));
    check("sb_empty", 64'(q.size()), 64'd0);
`ifdef KNN_SEQ_PERF_EN
    check("perf_cycles", 64'(perf_cycles), 64'(lat));
`endif
  endtask

  task automatic wait_rank(input logic [1:0] rk);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(res_valid && res_rank == rk) && n < 200);
    if (n >= 200) check("rank_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    // Points (x,y) on the diagonal; word layout {y,x}.
    ram[0] = {16'd10, 16'd10};
    ram[1] = {16'd50, 16'd50};
    ram[2] = {16'd30, 16'd30};
    ram[3] = {16'd0, 16'd0};
    ram[4] = {16'd100, 16'd100};
    ram[5] = {16'd20, 16'd20};
    ram[6] = {16'd60, 16'd60};
    ram[7] = {16'd5, 16'd5};

    vecs[0] = '{n: 16'd4, xy: {16'd0, 16'd0},   lab: '{8'h13, 8'h10, 8'h12, 8'h11}};
    vecs[1] = '{n: 16'd4, xy: {16'd50, 16'd50}, lab: '{8'h11, 8'h12, 8'h10, 8'h13}};
    vecs[2] = '{n: 16'd2, xy: {16'd0, 16'd0},   lab: '{8'h10, 8'h11, 8'hFF, 8'hFF}};
    vecs[3] = '{n: 16'd8, xy: {16'd25, 16'd26}, lab: '{8'h12, 8'h15, 8'h10, 8'h17}};
    vecs[4] = '{n: 16'd0, xy: {16'd7, 16'd9},   lab: '{8'h00, 8'h00, 8'h00, 8'h00}};

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      start_run(vecs[i]);
      finish_run(vecs[i], 0);
    end

    // Consumer stalls five cycles on rank 1.
    start_run(vecs[0]);
    wait_rank(2'd0);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(res_valid), 64'd1);
      check("stall_rank", 64'(res_rank), 64'd1);
      check("stall_sel", 64'(srt_sel), 64'd1);
      check("stall_label", 64'(res_label), 64'h10);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    finish_run(vecs[0], 5);

    // Start pulse mid-stream with a different n_train must be ignored.
    start_run(vecs[3]);
    repeat (3) @(posedge clk);
    #1;
    start   = 1'b1;
    n_train = 16'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_run(vecs[3], 0);

    // Start coinciding with run_done must be ignored.
    start_run(vecs[1]);
    wait_rank(2'd3);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(negedge clk);
    check("rd_cycle_done", 64'(run_done), 64'd1);
    check("rd_cycle_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("rd_start_ignored", 64'({busy, srt_clr}), 64'd0);
    finish_run(vecs[1], 0);

    // Reset during streaming aborts without run_done, then a clean run follows.
    start_run(vecs[3]);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(dcnt), 64'd0);
    start_run(vecs[0]);
    finish_run(vecs[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
